alu_result_queue: RTL and testbench

Result buffer placed directly downstream of the ALU (the arithmetic, shift, and other-function units). Each cycle it captures the ALU result word, overflow flag, and function code into a small FIFO. It hands the entries to the consumer over a valid/ready handshake, so the ALU can keep producing while the consumer stalls. It also keeps a sticky overflow status for software-visible error reporting.

---
 rtl/alu_result_queue.sv | 105 ++++++++++
 tb/tb_alu_result_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_queue.sv
// Result FIFO behind the ALU with valid/ready output and sticky overflow status.
// Define ALU_QUEUE_OVF_COUNT_EN to build the saturating overflow counter.
module alu_result_queue #(
    parameter int data_width = 16,
    parameter int depth      = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [data_width-1:0]   in_C,
    input  logic                    in_OverflowFlag,
    input  logic [3:0]              in_FuncCode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [data_width-1:0]   out_C,
    output logic                    out_OverflowFlag,
    output logic [3:0]              out_FuncCode,
    output logic [$clog2(depth):0]  count,
    output logic                    sticky_ovf,
    input  logic                    clear_sticky,
    output logic [7:0]              ovf_count
);
    localparam int PW = $clog2(depth);
    localparam int CW = PW + 1;
    localparam int EW = data_width + 5;

    logic [depth-1:0][EW-1:0] mem_q, mem_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     sticky_q, sticky_d;
    logic                     push, pop, push_ovf;

    // Handshake depends only on registered occupancy; a full queue never
    // accepts, even when the head is leaving this cycle.
    assign in_ready  = (count_q != CW'(depth));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign push_ovf  = push && in_OverflowFlag;

    assign {out_C, out_OverflowFlag, out_FuncCode} = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign sticky_ovf = sticky_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        sticky_d = sticky_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_C, in_OverflowFlag, in_FuncCode};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        if (clear_sticky)
            sticky_d = 1'b0;
        if (push_ovf)
            sticky_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

`ifdef ALU_QUEUE_OVF_COUNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    // A clear that coincides with an overflow push restarts the count at 1.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clear_sticky)
            ovf_cnt_d = push_ovf ? 8'd1 : 8'd0;
        else if (push_ovf && ovf_cnt_q != 8'hff)
            ovf_cnt_d = ovf_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ovf_cnt_q <= '0;
        else          ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_count = ovf_cnt_q;
`else
    assign ovf_count = 8'd0;
`endif
endmodule

// File: tb/tb_alu_result_queue.sv
// Directed self-checking bench for alu_result_queue (depth 4, 16-bit data).
module tb_alu_result_queue;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, in_OverflowFlag;
    logic [15:0] in_C, out_C;
    logic [3:0]  in_FuncCode, out_FuncCode;
    logic        out_valid, out_ready, out_OverflowFlag;
    logic [2:0]  count;
    logic        sticky_ovf, clear_sticky;
    logic [7:0]  ovf_count;

    int n_cmp = 0;
    int n_err = 0;

    alu_result_queue #(.data_width(16), .depth(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_C(in_C),
        .in_OverflowFlag(in_OverflowFlag), .in_FuncCode(in_FuncCode),
        .out_valid(out_valid), .out_ready(out_ready), .out_C(out_C),
        .out_OverflowFlag(out_OverflowFlag), .out_FuncCode(out_FuncCode),
        .count(count), .sticky_ovf(sticky_ovf), .clear_sticky(clear_sticky),
        .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b1; in_C = 16'h1234; in_FuncCode = 4'b0010;
        in_OverflowFlag = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
        tick(); tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_C", 32'(out_C), 32'h0000);
        check("rst_sticky", 32'(sticky_ovf), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        reset_n = 1'b1;
        tick();
        check("first_out_C", 32'(out_C), 32'h1234);
        check("first_func", 32'(out_FuncCode), 32'h2);
        check("first_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("first_drained", 32'(out_valid), 32'd0);

        // Fill to full with the consumer stalled, then a rejected 5th push.
        out_ready = 1'b0; in_FuncCode = 4'h1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_C = 16'(i);
            tick();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_C = 16'h0005;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("full_pop_no_push_count", 32'(count), 32'd3);
        in_valid = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data", 32'(out_C), 32'(i));
            tick();
        end
        check("drain_empty_valid", 32'(out_valid), 32'd0);
        check("drain_empty_count", 32'(count), 32'd0);

        // Streaming: one in, one out each cycle.
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_C = 16'h0010 + 16'(i);
            tick();
            check("stream_count", 32'(count), 32'd1);
            check("stream_data", 32'(out_C), 32'h10 + 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_valid", 32'(out_valid), 32'd0);

        // Overflow / sticky behaviour.
        out_ready = 1'b0; in_valid = 1'b1;
        in_C = 16'h00a1; tick();
        in_C = 16'h00a2; tick();
        in_C = 16'h8000; in_OverflowFlag = 1'b1; in_FuncCode = 4'h7;
        tick();
        check("ovf_sticky_set", 32'(sticky_ovf), 32'd1);
        check("ovf_count3", 32'(count), 32'd3);
        check("ovf_head", 32'(out_C), 32'h00a1);
        clear_sticky = 1'b1; in_C = 16'h8001;
        tick();
        check("clr_and_set_sticky", 32'(sticky_ovf), 32'd1);
`ifdef ALU_QUEUE_OVF_COUNT_EN
        check("clr_and_set_ovf_count", 32'(ovf_count), 32'd1);
`else
        check("clr_and_set_ovf_count", 32'(ovf_count), 32'd0);
`endif
        check("ovf_full", 32'(count), 32'd4);
        in_valid = 1'b0;
        tick();
        check("clear_sticky", 32'(sticky_ovf), 32'd0);
        check("clear_ovf_count", 32'(ovf_count), 32'd0);
        clear_sticky = 1'b0; in_valid = 1'b1;
        tick();
        check("ignored_push_no_sticky", 32'(sticky_ovf), 32'd0);
        check("ignored_push_count", 32'(count), 32'd4);
        in_valid = 1'b0; in_OverflowFlag = 1'b0;

        // Asynchronous reset with 3 entries queued.
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("pre_reset_count", 32'(count), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_out_C", 32'(out_C), 32'h0000);
        check("async_rst_in_ready", 32'(in_ready), 32'd1);
        #1 reset_n = 1'b1;
        tick();
        check("post_rst_empty", 32'(out_valid), 32'd0);
        in_valid = 1'b1; in_C = 16'h00aa; in_FuncCode = 4'h3;
        tick();
        in_valid = 1'b0;
        check("post_rst_data", 32'(out_C), 32'h00aa);
        check("post_rst_ovf_flag", 32'(out_OverflowFlag), 32'd0);

        // Saturation of the overflow counter while streaming.
        out_ready = 1'b1; tick();
        in_valid = 1'b1; in_OverflowFlag = 1'b1; in_FuncCode = 4'h9;
        for (int i = 0; i < 260; i++) begin
            in_C = 16'(i);
            tick();
            if (i == 9) begin
`ifdef ALU_QUEUE_OVF_COUNT_EN
                check("ovf_count_10", 32'(ovf_count), 32'd10);
`else
                check("ovf_count_10", 32'(ovf_count), 32'd0);
`endif
            end
        end
        in_valid = 1'b0;
`ifdef ALU_QUEUE_OVF_COUNT_EN
        check("ovf_count_sat", 32'(ovf_count), 32'd255);
`else
        check("ovf_count_sat", 32'(ovf_count), 32'd0);
`endif
        check("sat_sticky", 32'(sticky_ovf), 32'd1);
        check("sat_head_ovf", 32'(out_OverflowFlag), 32'd1);
        check("sat_head_func", 32'(out_FuncCode), 32'h9);
        check("sat_head_data", 32'(out_C), 32'd259);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
